// File: rtl/img_cam_pkg.sv
// Shared types and default widths for the ram_img CAM sequencer and its CAM instantiations.
package img_cam_pkg;

  localparam int CAM_KEY_W = 24;
  localparam int CAM_TAG_W = 14;

  // Round-robin pointer value that favours the load requester.
  localparam logic PTR_LD = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SEARCH,
    ST_WAIT,
    ST_RESULT
  } cam_state_t;

endpackage

// File: rtl/img_cam_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter: bit 0 = load, bit 1 = search.
// The pointer flips only when both eligible requesters compete while update is enabled.
module rr_arb2
  import img_cam_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] elig,
  input  logic       upd_en,
  output logic [1:0] gnt
);

  logic       ptr;
  logic [1:0] cand;

  assign cand = req & elig;

  always_comb begin
    gnt = cand;
    if (cand == 2'b11) gnt = (ptr == PTR_LD) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= PTR_LD;
    else if (upd_en && cand == 2'b11) ptr <= ~ptr;
  end

endmodule

// File: rtl/img_cam_ctrl.sv
// Sequencer for the ram_img CAM: arbitrates loads/searches, times we/match_en, returns results.
// state     | meaning
// ST_IDLE   | arbitrate between pending load and search requests
// ST_WRITE  | cam_we high for one cycle with captured key/tag
// ST_SEARCH | cam_match_en high for one cycle with captured key
// ST_WAIT   | down-count MATCH_LAT cycles, sample cam_match at terminal count
// ST_RESULT | hold res_valid/res_match until res_ready
module img_cam_ctrl
  import img_cam_pkg::*;
#(
  parameter  int KEY_W     = CAM_KEY_W,
  parameter  int TAG_W     = CAM_TAG_W,
  parameter  int DEPTH     = 16,
  parameter  int MATCH_LAT = 1,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [KEY_W-1:0] ld_key,
  input  logic [TAG_W-1:0] ld_tag,
  input  logic             sr_valid,
  output logic             sr_ready,
  input  logic [KEY_W-1:0] sr_key,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_match,
  output logic             cam_we,
  output logic             cam_match_en,
  output logic [KEY_W-1:0] cam_addr,
  output logic [TAG_W-1:0] cam_din,
  input  logic             cam_match,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  cam_state_t state;
  logic [2:0] wait_cnt;
  logic [1:0] gnt;
  logic       idle;

  assign idle     = (state == ST_IDLE) && !rst;
  assign full     = (count == CNT_W'(DEPTH));
  assign ld_ready = idle && gnt[0];
  assign sr_ready = idle && gnt[1];

  // A load is ineligible while full so a waiting search is never blocked by it.
  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({sr_valid, ld_valid}),
    .elig   ({1'b1, !full}),
    .upd_en (idle),
    .gnt    (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cam_we       <= 1'b0;
      cam_match_en <= 1'b0;
      cam_addr     <= '0;
      cam_din      <= '0;
      res_valid    <= 1'b0;
      res_match    <= 1'b0;
      count        <= '0;
      wait_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ld_valid && ld_ready) begin
            cam_addr <= ld_key;
            cam_din  <= ld_tag;
            cam_we   <= 1'b1;
            state    <= ST_WRITE;
          end else if (sr_valid && sr_ready) begin
            cam_addr     <= sr_key;
            cam_match_en <= 1'b1;
            state        <= ST_SEARCH;
          end
        end
        ST_WRITE: begin
          cam_we <= 1'b0;
          if (!full) count <= count + CNT_W'(1);
          state <= ST_IDLE;
        end
        ST_SEARCH: begin
          cam_match_en <= 1'b0;
          wait_cnt     <= 3'(MATCH_LAT - 1);
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == 3'd0) begin
            res_match <= cam_match;
            res_valid <= 1'b1;
            state     <= ST_RESULT;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_match <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_cam_ctrl.sv
// Self-checking bench for img_cam_ctrl with a behavioural CAM and a key-set reference model.
module tb_img_cam_ctrl;

  localparam int KW    = 24;
  localparam int TW    = 14;
  localparam int DEPTH = 16;
  localparam int ML    = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_valid = 1'b0, sr_valid = 1'b0, res_ready = 1'b1;
  logic [KW-1:0] ld_key = '0, sr_key = '0;
  logic [TW-1:0] ld_tag = '0;
  logic          ld_ready, sr_ready, res_valid, res_match;
  logic          cam_we, cam_match_en, full;
  logic [KW-1:0] cam_addr;
  logic [TW-1:0] cam_din;
  logic          cam_match = 1'b0;
  logic [4:0]    count;

  int checks = 0;
  int errors = 0;

  logic [KW-1:0] cam_mem[$];
  logic [KW-1:0] ref_keys[$];
  int            ref_count = 0;

  img_cam_ctrl #(.KEY_W(KW), .TAG_W(TW), .DEPTH(DEPTH), .MATCH_LAT(ML)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_key(ld_key), .ld_tag(ld_tag),
    .sr_valid(sr_valid), .sr_ready(sr_ready), .sr_key(sr_key),
    .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
    .cam_we(cam_we), .cam_match_en(cam_match_en), .cam_addr(cam_addr), .cam_din(cam_din),
    .cam_match(cam_match), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  function automatic bit in_q(input logic [KW-1:0] q[$], input logic [KW-1:0] k);
    foreach (q[i]) if (q[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  // Behavioural CAM: stores on we, answers one cycle after match_en (MATCH_LAT = 1).
  always @(posedge clk) begin
    if (cam_we) cam_mem.push_back(cam_addr);
    cam_match <= cam_match_en && in_q(cam_mem, cam_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, 32'(cam_we), 0);
    chk({tag, "_me"}, 32'(cam_match_en), 0);
    chk({tag, "_addr"}, 32'(cam_addr), 0);
    chk({tag, "_din"}, 32'(cam_din), 0);
    chk({tag, "_rv"}, 32'(res_valid), 0);
    chk({tag, "_rm"}, 32'(res_match), 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_ldr"}, 32'(ld_ready), 0);
    chk({tag, "_srr"}, 32'(sr_ready), 0);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1; ld_valid = 1'b0; sr_valid = 1'b0; res_ready = 1'b1;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    ref_count = 0;
  endtask

  task automatic do_load(input logic [KW-1:0] k, input logic [TW-1:0] t);
    int n = 0;
    step();
    ld_valid = 1'b1; ld_key = k; ld_tag = t;
    #1;
    while (!ld_ready && n < 50) begin step(); n++; end
    if (!ld_ready) begin
      chk("ld_accept_timeout", 32'(ld_ready), 1);
      ld_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 ld_valid = 1'b0;
    ref_keys.push_back(k);
    if (ref_count < DEPTH) ref_count++;
    step();
    chk("ld_we", 32'(cam_we), 1);
    chk("ld_me", 32'(cam_match_en), 0);
    chk("ld_addr", 32'(cam_addr), 32'(k));
    chk("ld_din", 32'(cam_din), 32'(t));
    step();
    chk("ld_we_drop", 32'(cam_we), 0);
    chk("ld_count", 32'(count), 32'(ref_count));
    chk("ld_full", 32'(full), 32'(ref_count == DEPTH));
  endtask

  task automatic do_search(input logic [KW-1:0] k, input bit exp, input int hold);
    int n = 0;
    step();
    sr_valid = 1'b1; sr_key = k; res_ready = (hold == 0);
    #1;
    while (!sr_ready && n < 50) begin step(); n++; end
    if (!sr_ready) begin
      chk("sr_accept_timeout", 32'(sr_ready), 1);
      sr_valid = 1'b0; res_ready = 1'b1;
      return;
    end
    @(posedge clk);
    #1 sr_valid = 1'b0;
    step();
    chk("sr_me", 32'(cam_match_en), 1);
    chk("sr_we", 32'(cam_we), 0);
    chk("sr_addr", 32'(cam_addr), 32'(k));
    for (int i = 0; i < ML; i++) begin
      step();
      chk("sr_latency", 32'(res_valid), 0);
    end
    step();
    chk("sr_res_valid", 32'(res_valid), 1);
    chk("sr_res_match", 32'(res_match), 32'(exp));
    if (hold > 0) begin
      ld_valid = 1'b1; sr_valid = 1'b1;
      #1;
      for (int h = 0; h < hold; h++) begin
        chk("bp_valid", 32'(res_valid), 1);
        chk("bp_match", 32'(res_match), 32'(exp));
        chk("bp_ld_ready", 32'(ld_ready), 0);
        chk("bp_sr_ready", 32'(sr_ready), 0);
        if (h < hold - 1) step();
      end
      res_ready = 1'b1;
      step();
      chk("bp_release_rv", 32'(res_valid), 0);
      chk("bp_release_idle", 32'(ld_ready | sr_ready), 1);
      ld_valid = 1'b0; sr_valid = 1'b0;
    end else begin
      step();
      chk("sr_res_drop", 32'(res_valid), 0);
    end
    res_ready = 1'b1;
  endtask

  typedef struct {
    bit            is_load;
    logic [KW-1:0] key;
    logic [TW-1:0] tag;
    bit            exp_match;
    int            exp_count;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 24'hFF00F2, 14'h0001, 1'b0, 1};
    tbl[1] = '{1'b1, 24'hAAAAAA, 14'h0002, 1'b0, 2};
    tbl[2] = '{1'b0, 24'hFF00F2, 14'h0000, 1'b1, 0};
    tbl[3] = '{1'b0, 24'h123456, 14'h0000, 1'b0, 0};
    tbl[4] = '{1'b0, 24'hAAAAAA, 14'h0000, 1'b1, 0};
    tbl[5] = '{1'b1, 24'h123456, 14'h0003, 1'b0, 3};
    tbl[6] = '{1'b0, 24'h123456, 14'h0000, 1'b1, 0};

    do_reset();

    foreach (tbl[i]) begin
      if (tbl[i].is_load) begin
        do_load(tbl[i].key, tbl[i].tag);
        chk("tbl_count", 32'(count), 32'(tbl[i].exp_count));
      end else begin
        do_search(tbl[i].key, tbl[i].exp_match, 0);
      end
    end

    // Backpressure: result held five cycles with both requesters knocking.
    do_search(24'hFF00F2, 1'b1, 5);

    // Randomised mix against the key-set reference.
    for (int r = 0; r < 24; r++) begin
      logic [KW-1:0] k;
      if ($urandom_range(0, 1) == 1 && ref_count < 12) begin
        k = KW'($urandom());
        do_load(k, TW'($urandom()));
      end else begin
        if ($urandom_range(0, 1) == 1) k = ref_keys[$urandom_range(0, ref_keys.size() - 1)];
        else k = KW'($urandom());
        do_search(k, in_q(ref_keys, k), $urandom_range(0, 2));
      end
    end

    // Both requesters held from reset: grants alternate, L every 6 cycles, S 2 cycles later.
    begin
      string grants = "";
      do_reset();
      ld_valid = 1'b1; ld_key = 24'h00ABCD; ld_tag = 14'h0ABC;
      sr_valid = 1'b1; sr_key = 24'h00ABCD; res_ready = 1'b1;
      #1;
      for (int c = 0; c < 40; c++) begin
        chk("alt_excl_ready", 32'(ld_ready & sr_ready), 0);
        chk("alt_excl_pins", 32'(cam_we & cam_match_en), 0);
        if (ld_ready) begin grants = {grants, "L"}; ref_keys.push_back(ld_key); end
        if (sr_ready) grants = {grants, "S"};
        step();
      end
      ld_valid = 1'b0; sr_valid = 1'b0;
      chk("alt_grant_count", 32'(grants.len()), 14);
      if (grants.len() >= 6) begin
        for (int g = 0; g < 6; g++)
          chk("alt_order", 32'(grants[g]), (g % 2 == 0) ? 32'("L") : 32'("S"));
      end
      repeat (8) step();
    end

    // Fill to DEPTH, then a load stays refused while a search is still served.
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_load(24'(32'h100 + i), 14'(i));
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), DEPTH);
    step();
    ld_valid = 1'b1; ld_key = 24'h999999; ld_tag = 14'h1111;
    sr_valid = 1'b1; sr_key = 24'h000105;
    #1;
    chk("full_ld_ready", 32'(ld_ready), 0);
    chk("full_sr_ready", 32'(sr_ready), 1);
    sr_valid = 1'b0;
    do_search(24'h000105, 1'b1, 0);
    for (int c = 0; c < 5; c++) begin
      chk("full_hold_ld_ready", 32'(ld_ready), 0);
      chk("full_hold_count", 32'(count), DEPTH);
      step();
    end
    ld_valid = 1'b0;

    // Reset while waiting on the CAM: outputs clear, no result ever appears.
    begin
      int n = 0;
      step();
      sr_valid = 1'b1; sr_key = 24'h000100; res_ready = 1'b1;
      #1;
      while (!sr_ready && n < 50) begin step(); n++; end
      chk("rstw_accept", 32'(sr_ready), 1);
      @(posedge clk);
      #1 sr_valid = 1'b0;
      step();
      chk("rstw_me", 32'(cam_match_en), 1);
      step();
      chk("rstw_wait_rv", 32'(res_valid), 0);
      rst = 1'b1;
      step();
      chk_all_zero("rstw");
      rst = 1'b0;
      ref_count = 0;
      for (int c = 0; c < 6; c++) begin
        step();
        chk("rstw_no_result", 32'(res_valid), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
